// File: rtl/cc_line_fill_engine.sv
`default_nettype none
// ============================================================================
// Module      : cc_line_fill_engine
// Description : Cache refill path. Pops a missed address from the miss FIFO,
//               collects the AXI R-channel burst for that line in
//               critical-word-first wrap order and writes the completed line,
//               set index and tag into the cache SRAM write port.
//               Optional macro CC_CRIT_WORD_FWD_EN adds a one-cycle forward
//               of the first received beat (fwd_valid_o / fwd_data_o).
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module cc_line_fill_engine #(
    parameter int DATA_W     = 64,
    parameter int LINE_BYTES = 64,
    parameter int ADDR_W     = 32,
    parameter int INDEX_W    = 9
) (
    input  logic                                           clk,
    input  logic                                           rst,
    // AXI R channel
    input  logic [DATA_W-1:0]                              mem_rdata_i,
    input  logic [1:0]                                     mem_rresp_i,
    input  logic                                           mem_rlast_i,
    input  logic                                           mem_rvalid_i,
    output logic                                           mem_rready_o,
    // Miss-address FIFO (first-word-fall-through)
    input  logic                                           miss_addr_fifo_empty_i,
    input  logic [ADDR_W-1:0]                              miss_addr_fifo_rdata_i,
    output logic                                           miss_addr_fifo_rden_o,
    // Cache SRAM write port
    output logic                                           wren_o,
    output logic [INDEX_W-1:0]                             waddr_o,
    output logic [ADDR_W-INDEX_W-$clog2(LINE_BYTES):0]     wdata_tag_o,
    output logic [LINE_BYTES*8-1:0]                        wdata_data_o,
`ifdef CC_CRIT_WORD_FWD_EN
    // Critical-word forward to the CPU
    output logic                                           fwd_valid_o,
    output logic [DATA_W-1:0]                              fwd_data_o,
`endif
    output logic                                           fill_err_o
);

    // ------------------------------------------------------------------------
    // Derived geometry
    // ------------------------------------------------------------------------
    localparam int c_BEATS  = LINE_BYTES * 8 / DATA_W;
    localparam int c_OFF_W  = $clog2(LINE_BYTES);
    localparam int c_BYTE_W = $clog2(DATA_W / 8);
    localparam int c_BEAT_W = $clog2(c_BEATS);
    localparam int c_TAG_W  = ADDR_W - INDEX_W - c_OFF_W;

    localparam logic [c_BEAT_W-1:0] c_LAST_CNT = c_BEAT_W'(c_BEATS - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FILL  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;

    logic [1:0]          r_state;
    logic [c_BEAT_W-1:0] r_cnt;      // beats received in the current fill
    logic [c_BEAT_W-1:0] r_off;      // critical (start) beat of the line
    logic                r_err;      // sticky error of the current fill
    logic [INDEX_W-1:0]  r_index;
    logic [c_TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0]   r_line [c_BEATS];

    logic                w_pop;
    logic                w_hs;
    logic                w_cnt_last;
    logic                w_beat_err;
    logic                w_err_nxt;
    logic                w_done;
    logic [c_BEAT_W-1:0] w_slot;
    logic                w_unused;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    // The pop is the only unregistered output: the FIFO head is consumed in
    // the same cycle its address is captured.
    assign w_pop                 = (r_state == c_IDLE) & ~miss_addr_fifo_empty_i;
    assign miss_addr_fifo_rden_o = w_pop;

    assign w_hs       = (r_state == c_FILL) & mem_rvalid_i & mem_rready_o;
    assign w_cnt_last = (r_cnt == c_LAST_CNT);
    assign w_done     = w_hs & (w_cnt_last | mem_rlast_i);

    // Slave error, RLAST too early, or RLAST missing on the final beat.
    assign w_beat_err = mem_rresp_i[1]
                      | (mem_rlast_i & ~w_cnt_last)
                      | (w_cnt_last & ~mem_rlast_i);
    assign w_err_nxt  = r_err | w_beat_err;

    // Wrap order falls out of modulo-BEATS addition on c_BEAT_W bits.
    assign w_slot = r_off + r_cnt;

    // Byte-within-beat address bits and RRESP[0] carry no meaning here.
    assign w_unused = &{1'b0, mem_rresp_i[0], miss_addr_fifo_rdata_i};

    // ------------------------------------------------------------------------
    // FSM, beat counter, error flag, captured address fields and RREADY
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_off        <= '0;
            r_err        <= 1'b0;
            r_index      <= '0;
            r_tag        <= '0;
            mem_rready_o <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_pop) begin
                        r_index      <= miss_addr_fifo_rdata_i[c_OFF_W +: INDEX_W];
                        r_tag        <= miss_addr_fifo_rdata_i[ADDR_W-1 -: c_TAG_W];
                        r_off        <= miss_addr_fifo_rdata_i[c_BYTE_W +: c_BEAT_W];
                        r_state      <= c_FILL;
                        mem_rready_o <= 1'b1;
                    end
                end
                c_FILL: begin
                    if (w_hs) begin
                        r_cnt <= r_cnt + 1'b1;
                        r_err <= w_err_nxt;
                        if (w_cnt_last || mem_rlast_i) begin
                            r_state      <= c_WRITE;
                            mem_rready_o <= 1'b0;
                        end
                    end
                end
                c_WRITE: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state      <= c_IDLE;
                    mem_rready_o <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // SRAM write strobe, error pulse and held index/tag (loaded on the last
    // beat so they appear together with wren_o and stay until the next write)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wren_o      <= 1'b0;
            fill_err_o  <= 1'b0;
            waddr_o     <= '0;
            wdata_tag_o <= '0;
        end else begin
            wren_o     <= w_done;
            fill_err_o <= w_done & w_err_nxt;
            if (w_done) begin
                waddr_o     <= r_index;
                wdata_tag_o <= {~w_err_nxt, r_tag};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Line buffer: each accepted beat lands in its wrapped slot; slots not
    // received keep their previous content
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_BEATS; i++) begin
                r_line[i] <= '0;
            end
        end else if (w_hs) begin
            r_line[w_slot] <= mem_rdata_i;
        end
    end

    for (genvar k = 0; k < c_BEATS; k++) begin : g_pack
        assign wdata_data_o[k*DATA_W +: DATA_W] = r_line[k];
    end

`ifdef CC_CRIT_WORD_FWD_EN
    // ------------------------------------------------------------------------
    // Critical-word forward: first beat of every fill, independent of RRESP
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_valid_o <= 1'b0;
            fwd_data_o  <= '0;
        end else begin
            fwd_valid_o <= w_hs & (r_cnt == '0);
            if (w_hs && (r_cnt == '0)) begin
                fwd_data_o <= mem_rdata_i;
            end
        end
    end
`endif

endmodule
`default_nettype wire
